seg7_scan: RTL and testbench

//  Downstream consumer of the binary-to-BCD converter (score/timer path).
//  - Takes three BCD digits (dec0 = ones, dec1 = tens, dec2 = hundreds).
//  - Drives a time-multiplexed, common-anode 4-digit 7-segment display: prescaled refresh, one digit lit per slot.
//  - Inputs are captured once per scan frame, so the display never shows a torn value.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_scan_decode.sv | 11 +
 rtl/seg7_scan.sv | 86 ++++++++
 tb/tb_seg7_scan.sv | 134 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and BCD-to-segment lookup for the 7-segment scan driver.
package seg7_pkg;

    localparam int       NUM_DIGITS = 3;
    localparam bit [6:0] SEG_OFF    = 7'h7F;
    localparam bit [6:0] SEG_DASH   = 7'b0111111;
    localparam bit [3:0] AN_OFF     = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes render as a dash.
    function automatic logic [6:0] bcd2seg(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_decode.sv
// Combinational BCD to active-low segment pattern lookup.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = bcd2seg(i_bcd);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 3-digit scan driver with per-frame input capture.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dec0,
    input  logic [3:0] dec1,
    input  logic [3:0] dec2,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    logic [CNT_W-1:0] r_pcnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_shadow [NUM_DIGITS];
    logic [3:0]       r_an_p1;
    logic [6:0]       r_seg_p1;

    logic             w_tick;
    logic [3:0]       w_cur_bcd;
    logic [6:0]       w_seg;
    logic             w_lzb_dark;
    logic             w_dark;

    assign w_tick = (r_pcnt == CNT_W'(CLK_DIV - 1));

    always_comb begin
        w_cur_bcd = r_shadow[0];
        case (r_idx)
            2'd1:    w_cur_bcd = r_shadow[1];
            2'd2:    w_cur_bcd = r_shadow[2];
            default: w_cur_bcd = r_shadow[0];
        endcase
    end

    seg7_decode u_decode (
        .i_bcd (w_cur_bcd),
        .o_seg (w_seg)
    );

`ifdef SEG7_LZB_EN
    assign w_lzb_dark = ((r_idx == 2'd2) && (r_shadow[2] == 4'd0)) ||
                        ((r_idx == 2'd1) && (r_shadow[2] == 4'd0) && (r_shadow[1] == 4'd0));
`else
    assign w_lzb_dark = 1'b0;
`endif

    // idx==3 never drives anode 3; treat that slot as dark until the next tick recovers.
    assign w_dark = blank || w_lzb_dark || (r_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt   <= '0;
            r_idx    <= 2'd0;
            for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= 4'd0;
            r_an_p1  <= AN_OFF;
            r_seg_p1 <= SEG_OFF;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx >= 2'd2) ? 2'd0 : r_idx + 2'd1;
                // Frame wrap: capture all digits together so the display never tears.
                if (r_idx == 2'd2) begin
                    r_shadow[0] <= dec0;
                    r_shadow[1] <= dec1;
                    r_shadow[2] <= dec2;
                end
            end
            // Output stage: one cycle behind idx/shadow.
            r_an_p1  <= w_dark ? AN_OFF  : ~(4'b0001 << r_idx);
            r_seg_p1 <= w_dark ? SEG_OFF : w_seg;
        end
    end

    assign an  = r_an_p1;
    assign seg = r_seg_p1;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed table-driven bench for seg7_scan at CLK_DIV=4; honours SEG7_LZB_EN.
module tb_seg7_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dec0, dec1, dec2;
    logic       blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

`ifdef SEG7_LZB_EN
    localparam logic [3:0] AN1Z = 4'hF;
    localparam logic [3:0] AN2Z = 4'hF;
    localparam logic [6:0] SEGZ = 7'h7F;
`else
    localparam logic [3:0] AN1Z = 4'hD;
    localparam logic [3:0] AN2Z = 4'hB;
    localparam logic [6:0] SEGZ = 7'h40;
`endif

    typedef struct {
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic       blk;
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [26];

    seg7_scan #(.CLK_DIV(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .dec0  (dec0),
        .dec1  (dec1),
        .dec2  (dec2),
        .blank (blank),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] ea, input logic [6:0] es);
        checks++;
        if (an !== ea || seg !== es || dp !== 1'b1) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                     nm, an, seg, dp, ea, es);
        end
    endtask

    initial begin
        // Cycles counted from reset release; slot changes every 4 cycles.
        vecs[0]  = '{4'd1, 4'd2,  4'd3, 1'b0, 4, 4'hE, 7'h40};
        vecs[1]  = '{4'd1, 4'd2,  4'd3, 1'b0, 4, AN1Z, SEGZ};
        vecs[2]  = '{4'd1, 4'd2,  4'd3, 1'b0, 4, AN2Z, SEGZ};
        vecs[3]  = '{4'd1, 4'd2,  4'd3, 1'b0, 4, 4'hE, 7'h30};
        vecs[4]  = '{4'd1, 4'd2,  4'd3, 1'b0, 4, 4'hD, 7'h24};
        vecs[5]  = '{4'd1, 4'd2,  4'd3, 1'b0, 4, 4'hB, 7'h79};
        vecs[6]  = '{4'd1, 4'd2,  4'd3, 1'b0, 4, 4'hE, 7'h30};
        vecs[7]  = '{4'd1, 4'd2,  4'd8, 1'b0, 4, 4'hD, 7'h24};
        vecs[8]  = '{4'd1, 4'd2,  4'd8, 1'b0, 4, 4'hB, 7'h79};
        vecs[9]  = '{4'd1, 4'd2,  4'd8, 1'b0, 4, 4'hE, 7'h00};
        vecs[10] = '{4'd1, 4'hC,  4'd8, 1'b0, 4, 4'hD, 7'h24};
        vecs[11] = '{4'd1, 4'hC,  4'd8, 1'b0, 4, 4'hB, 7'h79};
        vecs[12] = '{4'd1, 4'hC,  4'd8, 1'b0, 4, 4'hE, 7'h00};
        vecs[13] = '{4'd1, 4'hC,  4'd8, 1'b0, 4, 4'hD, 7'h3F};
        vecs[14] = '{4'd1, 4'hC,  4'd8, 1'b0, 4, 4'hB, 7'h79};
        vecs[15] = '{4'd1, 4'hC,  4'd8, 1'b0, 4, 4'hE, 7'h00};
        vecs[16] = '{4'd1, 4'hC,  4'd8, 1'b0, 1, 4'hD, 7'h3F};
        vecs[17] = '{4'd1, 4'hC,  4'd8, 1'b1, 2, 4'hF, 7'h7F};
        vecs[18] = '{4'd1, 4'hC,  4'd8, 1'b0, 1, 4'hD, 7'h3F};
        vecs[19] = '{4'd1, 4'hC,  4'd8, 1'b0, 4, 4'hB, 7'h79};
        vecs[20] = '{4'd0, 4'd0,  4'd7, 1'b0, 4, 4'hE, 7'h00};
        vecs[21] = '{4'd0, 4'd0,  4'd7, 1'b0, 4, 4'hD, 7'h3F};
        vecs[22] = '{4'd0, 4'd0,  4'd7, 1'b0, 4, 4'hB, 7'h79};
        vecs[23] = '{4'd0, 4'd0,  4'd7, 1'b0, 4, 4'hE, 7'h78};
        vecs[24] = '{4'd0, 4'd0,  4'd7, 1'b0, 4, AN1Z, SEGZ};
        vecs[25] = '{4'd0, 4'd0,  4'd7, 1'b0, 2, AN2Z, SEGZ};

        rst   = 1'b1;
        blank = 1'b0;
        dec2  = 4'd1;
        dec1  = 4'd2;
        dec0  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("reset%0d", i), 4'hF, 7'h7F);
        end
        rst = 1'b0;

        for (int r = 0; r < 26; r++) begin
            dec2  = vecs[r].d2;
            dec1  = vecs[r].d1;
            dec0  = vecs[r].d0;
            blank = vecs[r].blk;
            for (int k = 0; k < vecs[r].n; k++) begin
                cyc();
                check($sformatf("row%0d_c%0d", r, k), vecs[r].an, vecs[r].seg);
            end
        end

        // Now at pcnt=2, idx=2: a one-cycle reset must abort the frame.
        rst = 1'b1;
        cyc();
        check("midrst", 4'hF, 7'h7F);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("post_rst_s0_%0d", k), 4'hE, 7'h40);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("post_rst_s1_%0d", k), AN1Z, SEGZ);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
